// File: rtl/bin_morph_pkg.sv
// bin_morph_pkg: shared mode encodings, pipeline latency and elaboration
// helpers for the binary morphology filter.
package bin_morph_pkg;

    typedef enum logic [1:0] {
        MODE_ERODE  = 2'd0,
        MODE_DILATE = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

    localparam int LAT = 4;

    // Bit k set means a KSIZE of k is supported (3, 5 and 7).
    localparam int unsigned LEGAL_KSIZE_MASK = 32'h0000_00A8;

    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) result++;
        return result;
    endfunction

    function automatic bit ksize_legal(input int k);
        return (k >= 0) && (k < 32) && LEGAL_KSIZE_MASK[k];
    endfunction

endpackage

// File: rtl/bin_morph_window.sv
// bin_morph_window: line buffers, KSIZE x KSIZE window and border tracking for
// a 1-bit pixel stream; every output is one register stage behind the input.
module bin_morph_window
    import bin_morph_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int KSIZE     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pre_img_vsync,
    input  logic                   pre_img_hsync,
    input  logic                   pre_img_valid,
    input  logic                   pre_img_data,
    output logic [KSIZE*KSIZE-1:0] win_flat,
    output logic                   win_border,
    output logic                   win_vsync,
    output logic                   win_hsync,
    output logic                   win_valid
);
    localparam int            CW   = clog2(KSIZE);
    localparam logic [CW-1:0] KMAX = CW'(KSIZE - 1);

    logic [KSIZE-2:0][IMG_WIDTH-1:0] lb_q, lb_d;
    logic [KSIZE-1:0][KSIZE-1:0]     win_q, win_d;
    logic [KSIZE-1:0]                new_col;
    logic [CW-1:0]                   col_cnt_q, col_cnt_d;
    logic [CW-1:0]                   row_cnt_q, row_cnt_d;
    logic                            border_q, border_d;
    logic                            vsync_q, hsync_q, valid_q;

    // Row KSIZE-1 of the window is the live line; chain j holds line r-(j+1).
    always_comb begin
        new_col          = '0;
        new_col[KSIZE-1] = pre_img_data;
        for (int j = 1; j < KSIZE; j++) new_col[KSIZE-1-j] = lb_q[j-1][IMG_WIDTH-1];

        lb_d  = lb_q;
        win_d = win_q;
        if (pre_img_valid) begin
            lb_d[0] = {lb_q[0][IMG_WIDTH-2:0], pre_img_data};
            for (int j = 1; j < KSIZE - 1; j++)
                lb_d[j] = {lb_q[j][IMG_WIDTH-2:0], lb_q[j-1][IMG_WIDTH-1]};
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) win_d[r][c] = win_q[r][c+1];
                win_d[r][KSIZE-1] = new_col[r];
            end
        end
    end

    // vsync_q/valid_q double as the previous-cycle samples for edge detection.
    always_comb begin
        col_cnt_d = '0;
        if (pre_img_valid) col_cnt_d = (col_cnt_q == KMAX) ? KMAX : col_cnt_q + 1'b1;

        row_cnt_d = row_cnt_q;
        if (pre_img_vsync && !vsync_q)
            row_cnt_d = '0;
        else if (valid_q && !pre_img_valid && row_cnt_q != KMAX)
            row_cnt_d = row_cnt_q + 1'b1;

        border_d = (row_cnt_q < KMAX) || (col_cnt_q < KMAX);
    end

    // Line buffers are left unreset; border masking hides their stale contents.
    always_ff @(posedge clk) begin
        lb_q <= lb_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            border_q  <= 1'b0;
            vsync_q   <= 1'b0;
            hsync_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            win_q     <= win_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            border_q  <= border_d;
            vsync_q   <= pre_img_vsync;
            hsync_q   <= pre_img_hsync;
            valid_q   <= pre_img_valid;
        end
    end

    assign win_flat   = win_q;
    assign win_border = border_q;
    assign win_vsync  = vsync_q;
    assign win_hsync  = hsync_q;
    assign win_valid  = valid_q;

endmodule

// File: rtl/bin_morph_filter.sv
// bin_morph_filter: run-time selectable erosion / dilation / majority / bypass
// over a KSIZE x KSIZE window of a 1-bit pixel stream, LAT cycles end to end.
module bin_morph_filter
    import bin_morph_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int KSIZE     = 3,
    parameter bit EDGE_VAL  = 1'b0,
    parameter int CNT_W     = clog2(KSIZE * KSIZE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_img_vsync,
    input  logic             pre_img_hsync,
    input  logic             pre_img_valid,
    input  logic             pre_img_data,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_thresh,
    output logic             post_img_vsync,
    output logic             post_img_hsync,
    output logic             post_img_valid,
    output logic             post_img_data
);
    localparam int H    = (KSIZE - 1) / 2;
    localparam int AREA = KSIZE * KSIZE;
    localparam int RPW  = clog2(KSIZE + 1);

    if (!ksize_legal(KSIZE)) begin : g_bad_ksize
        $error("bin_morph_filter: KSIZE must be 3, 5 or 7");
    end

    logic [AREA-1:0]           win;
    logic                      win_border, win_vsync, win_hsync, win_valid;
    mode_e                     mode_q, mode_d;
    logic [CNT_W-1:0]          thresh_q, thresh_d;
    logic [KSIZE-1:0][RPW-1:0] row_pop_q, row_pop_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [1:0]                centre_q, centre_d;
    logic [1:0]                border_q, border_d;
    logic [LAT-2:0][2:0]       sync_q, sync_d;
    logic                      data_q, data_d;
    logic                      hit;

    bin_morph_window #(
        .IMG_WIDTH (IMG_WIDTH),
        .KSIZE     (KSIZE)
    ) u_window (
        .clk           (clk),
        .rst_n         (rst_n),
        .pre_img_vsync (pre_img_vsync),
        .pre_img_hsync (pre_img_hsync),
        .pre_img_valid (pre_img_valid),
        .pre_img_data  (pre_img_data),
        .win_flat      (win),
        .win_border    (win_border),
        .win_vsync     (win_vsync),
        .win_hsync     (win_hsync),
        .win_valid     (win_valid)
    );

    // win_vsync is the input vsync one cycle late, so this fires on its rising edge.
    always_comb begin
        mode_d   = mode_q;
        thresh_d = thresh_q;
        if (pre_img_vsync && !win_vsync) begin
            mode_d   = mode_e'(cfg_mode);
            thresh_d = cfg_thresh;
        end
    end

    // Index 0 of centre/border/sync is stage 2, index 1 stage 3, sync[2] stage 4.
    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            row_pop_d[r] = '0;
            for (int c = 0; c < KSIZE; c++)
                row_pop_d[r] = row_pop_d[r] + RPW'(win[r*KSIZE + c]);
        end

        cnt_d = '0;
        for (int r = 0; r < KSIZE; r++) cnt_d = cnt_d + CNT_W'(row_pop_q[r]);

        centre_d = {centre_q[0], win[H*KSIZE + H]};
        border_d = {border_q[0], win_border};
        sync_d   = {sync_q[LAT-3:0], win_vsync, win_hsync, win_valid};

        hit = 1'b0;
        case (mode_q)
            MODE_ERODE:  hit = (cnt_q == CNT_W'(AREA));
            MODE_DILATE: hit = (cnt_q != '0);
            MODE_THRESH: hit = (cnt_q >= thresh_q);
            MODE_BYPASS: hit = centre_q[1];
            default:     hit = 1'b0;
        endcase

        data_d = sync_q[LAT-3][0] && (border_q[1] ? EDGE_VAL : hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_ERODE;
            thresh_q  <= '0;
            row_pop_q <= '0;
            cnt_q     <= '0;
            centre_q  <= '0;
            border_q  <= '0;
            sync_q    <= '0;
            data_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            thresh_q  <= thresh_d;
            row_pop_q <= row_pop_d;
            cnt_q     <= cnt_d;
            centre_q  <= centre_d;
            border_q  <= border_d;
            sync_q    <= sync_d;
            data_q    <= data_d;
        end
    end

    assign post_img_vsync = sync_q[LAT-2][2];
    assign post_img_hsync = sync_q[LAT-2][1];
    assign post_img_valid = sync_q[LAT-2][0];
    assign post_img_data  = data_q;

endmodule

// File: tb/tb_bin_morph_filter.sv
// tb_bin_morph_filter: directed-frame bench for bin_morph_filter with an 8-pixel
// wide KSIZE=3 instance and a KSIZE=5 instance sharing one input stream.
module tb_bin_morph_filter;

    localparam logic HI = 1'b1;
    localparam logic LO = 1'b0;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b1;
    logic       vsync       = 1'b0;
    logic       hsync       = 1'b0;
    logic       valid       = 1'b0;
    logic       data        = 1'b0;
    logic [1:0] cfg_mode    = 2'd0;
    logic [3:0] cfg_thresh3 = 4'd0;
    logic [4:0] cfg_thresh5 = 5'd0;

    logic o3_vsync, o3_hsync, o3_valid, o3_data;
    logic o5_vsync, o5_hsync, o5_valid, o5_data;

    logic       in_img [0:7][0:7];
    logic       out3   [0:7][0:7];
    logic       out5   [0:7][0:7];
    logic [2:0] in_hist  [0:511];
    logic [2:0] out_hist [0:511];
    int         oc3, oc5, n_cyc;
    int         n_checks = 0;
    int         n_pass   = 0;

    bin_morph_filter #(.IMG_WIDTH(8), .KSIZE(3), .EDGE_VAL(1'b0)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .pre_img_vsync(vsync), .pre_img_hsync(hsync),
        .pre_img_valid(valid), .pre_img_data(data),
        .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh3),
        .post_img_vsync(o3_vsync), .post_img_hsync(o3_hsync),
        .post_img_valid(o3_valid), .post_img_data(o3_data)
    );

    bin_morph_filter #(.IMG_WIDTH(8), .KSIZE(5), .EDGE_VAL(1'b0)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .pre_img_vsync(vsync), .pre_img_hsync(hsync),
        .pre_img_valid(valid), .pre_img_data(data),
        .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh5),
        .post_img_vsync(o5_vsync), .post_img_hsync(o5_hsync),
        .post_img_valid(o5_valid), .post_img_data(o5_data)
    );

    always #5 clk = ~clk;

    // Sample this cycle's outputs, then drive this cycle's inputs, then advance.
    task automatic tick(input logic vs, input logic hs, input logic v, input logic d);
        if (n_cyc < 512) begin
            out_hist[n_cyc] = {o3_vsync, o3_hsync, o3_valid};
            in_hist[n_cyc]  = {vs, hs, v};
        end
        n_cyc++;
        if (o3_valid && oc3 < 64) begin out3[oc3/8][oc3%8] = o3_data; oc3++; end
        if (o5_valid && oc5 < 64) begin out5[oc5/8][oc5%8] = o5_data; oc5++; end
        vsync = vs; hsync = hs; valid = v; data = d;
        @(negedge clk);
    endtask

    task automatic run_frame(input int stop_row, input int sw_row, input logic [1:0] sw_mode);
        n_cyc = 0; oc3 = 0; oc5 = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin out3[r][c] = 1'bx; out5[r][c] = 1'bx; end
        repeat (2) tick(HI, LO, LO, LO);
        repeat (2) tick(LO, LO, LO, LO);
        for (int r = 0; r < 8; r++) begin
            if (r == sw_row) cfg_mode = sw_mode;
            for (int c = 0; c < 8; c++) begin
                if (r == stop_row && c == 4) return;
                tick(LO, HI, HI, in_img[r][c]);
            end
            repeat (3) tick(LO, LO, LO, LO);
        end
        repeat (8) tick(LO, LO, LO, LO);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vsync = 1'($urandom); hsync = 1'($urandom);
            valid = 1'($urandom); data  = 1'($urandom);
            cfg_mode = 2'($urandom);
            @(negedge clk);
            n_checks++;
            if ({o3_vsync, o3_hsync, o3_valid, o3_data, o5_vsync, o5_hsync, o5_valid, o5_data} !== 8'h00)
                $display("[TB] FAIL reset_hold cycle=%0d got %b expected 00000000", i,
                         {o3_vsync, o3_hsync, o3_valid, o3_data, o5_vsync, o5_hsync, o5_valid, o5_data});
            else n_pass++;
        end
        vsync = 1'b0; hsync = 1'b0; valid = 1'b0; data = 1'b0; cfg_mode = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o3_vsync, o3_hsync, o3_valid, o3_data, o5_vsync, o5_hsync, o5_valid, o5_data} !== 8'h00)
                $display("[TB] FAIL reset_idle cycle=%0d got %b expected 00000000", i,
                         {o3_vsync, o3_hsync, o3_valid, o3_data, o5_vsync, o5_hsync, o5_valid, o5_data});
            else n_pass++;
        end
    endtask

    task automatic test_erode_all_ones();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) in_img[r][c] = 1'b1;
        cfg_mode = 2'd0;
        run_frame(-1, -1, 2'd0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (out3[r][c] !== 1'((r >= 2) && (c >= 2)))
                    $display("[TB] FAIL erode_ones r=%0d c=%0d got %b expected %b",
                             r, c, out3[r][c], 1'((r >= 2) && (c >= 2)));
                else n_pass++;
            end
        n_checks++;
        if (oc3 !== 64) $display("[TB] FAIL erode_pixel_count got %0d expected 64", oc3);
        else n_pass++;
        for (int n = 4; n < n_cyc; n++) begin
            n_checks++;
            if (out_hist[n] !== in_hist[n-4])
                $display("[TB] FAIL sync_delay cycle=%0d got %b expected %b", n, out_hist[n], in_hist[n-4]);
            else n_pass++;
        end
    endtask

    task automatic test_dilate_single();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) in_img[r][c] = 1'b0;
        in_img[3][3] = 1'b1;
        cfg_mode = 2'd1;
        run_frame(-1, -1, 2'd1);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (out3[r][c] !== 1'(r >= 3 && r <= 5 && c >= 3 && c <= 5))
                    $display("[TB] FAIL dilate_single r=%0d c=%0d got %b expected %b",
                             r, c, out3[r][c], 1'(r >= 3 && r <= 5 && c >= 3 && c <= 5));
                else n_pass++;
            end
        cfg_mode = 2'd0;
        run_frame(-1, -1, 2'd0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (out3[r][c] !== 1'b0)
                    $display("[TB] FAIL erode_single r=%0d c=%0d got %b expected 0", r, c, out3[r][c]);
                else n_pass++;
            end
    endtask

    task automatic test_threshold_checker();
        logic [3:0] ths [0:3];
        logic       expv;
        ths[0] = 4'd5; ths[1] = 4'd4; ths[2] = 4'd0; ths[3] = 4'd15;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) in_img[r][c] = 1'(((r + c) % 2) == 0);
        cfg_mode = 2'd2;
        for (int t = 0; t < 4; t++) begin
            cfg_thresh3 = ths[t];
            run_frame(-1, -1, 2'd2);
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    // A 3x3 window on a checkerboard holds 5 ones when its centre is set, else 4.
                    if (r < 2 || c < 2) expv = 1'b0;
                    else expv = 1'((((r + c) % 2 == 0) ? 5 : 4) >= int'(ths[t]));
                    n_checks++;
                    if (out3[r][c] !== expv)
                        $display("[TB] FAIL thresh_%0d r=%0d c=%0d got %b expected %b",
                                 ths[t], r, c, out3[r][c], expv);
                    else n_pass++;
                end
        end
        cfg_thresh3 = 4'd0;
    endtask

    task automatic test_mode_switch();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) in_img[r][c] = 1'b0;
        in_img[3][3] = 1'b1;
        cfg_mode = 2'd1;
        run_frame(-1, 4, 2'd0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (out3[r][c] !== 1'(r >= 3 && r <= 5 && c >= 3 && c <= 5))
                    $display("[TB] FAIL switch_held r=%0d c=%0d got %b expected %b",
                             r, c, out3[r][c], 1'(r >= 3 && r <= 5 && c >= 3 && c <= 5));
                else n_pass++;
            end
        run_frame(-1, -1, 2'd0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (out3[r][c] !== 1'b0)
                    $display("[TB] FAIL switch_next r=%0d c=%0d got %b expected 0", r, c, out3[r][c]);
                else n_pass++;
            end
    endtask

    task automatic test_reset_mid_frame();
        logic e3, e5;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) in_img[r][c] = 1'($urandom);
        cfg_mode = 2'd3;
        run_frame(3, -1, 2'd3);
        n_checks++;
        if (o3_valid !== 1'b1) $display("[TB] FAIL pre_reset_valid got %b expected 1", o3_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o3_vsync, o3_hsync, o3_valid, o3_data, o5_vsync, o5_hsync, o5_valid, o5_data} !== 8'h00)
            $display("[TB] FAIL reset_async got %b expected 00000000",
                     {o3_vsync, o3_hsync, o3_valid, o3_data, o5_vsync, o5_hsync, o5_valid, o5_data});
        else n_pass++;
        vsync = 1'b0; hsync = 1'b0; valid = 1'b0; data = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(-1, -1, 2'd3);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                e5 = (r < 4 || c < 4) ? 1'b0 : in_img[r-2][c-2];
                e3 = (r < 2 || c < 2) ? 1'b0 : in_img[r-1][c-1];
                n_checks++;
                if (out5[r][c] !== e5)
                    $display("[TB] FAIL bypass_k5 r=%0d c=%0d got %b expected %b", r, c, out5[r][c], e5);
                else n_pass++;
                n_checks++;
                if (out3[r][c] !== e3)
                    $display("[TB] FAIL bypass_k3 r=%0d c=%0d got %b expected %b", r, c, out3[r][c], e3);
                else n_pass++;
            end
        n_checks++;
        if (oc5 !== 64) $display("[TB] FAIL bypass_k5_count got %0d expected 64", oc5);
        else n_pass++;
    endtask

    initial begin
        #1;
        test_reset();
        test_erode_all_ones();
        test_dilate_single();
        test_threshold_checker();
        test_mode_switch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
